// File: rtl/cci_mpf_shim_wr_heap_alloc.sv
// Write-heap slot allocator: a FIFO free list hands out slot indices to incoming
// AFU write packets and steers each beat into the heap RAM at (slot, beat).
module cci_mpf_shim_wr_heap_alloc #(
  parameter int N_WRITE_HEAP_ENTRIES = 32,
  parameter int N_DATA_BITS          = 512,
  parameter int N_CLNUM_BITS         = 2,
  localparam int IW                  = $clog2(N_WRITE_HEAP_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    afu_wr_valid,
  input  logic                    afu_wr_sop,
  input  logic [1:0]              afu_wr_cl_len,
  input  logic [N_DATA_BITS-1:0]  afu_wr_data,
  output logic                    afu_wr_rdy,
  output logic                    hdr_valid,
  output logic [IW-1:0]           hdr_idx,
  input  logic                    hdr_rdy,
  output logic                    heap_wen,
  output logic [IW-1:0]           heap_widx,
  output logic [N_CLNUM_BITS-1:0] heap_wclnum,
  output logic [N_DATA_BITS-1:0]  heap_wdata,
  input  logic                    free_en,
  input  logic [IW-1:0]           free_idx,
  output logic [IW:0]             num_free,
  output logic                    err
);

  localparam logic [IW:0] NUM_ENTRIES = (IW+1)'(N_WRITE_HEAP_ENTRIES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           fl_mem [N_WRITE_HEAP_ENTRIES];
  logic [IW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [IW:0]             num_free_q, num_free_d;
  logic [1:0]              beats_rem_q, beats_rem_d;
  logic [N_CLNUM_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]           pkt_idx_q, pkt_idx_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [IW-1:0]           hdr_idx_q, hdr_idx_d;
  logic                    heap_wen_q, heap_wen_d;
  logic [IW-1:0]           heap_widx_q, heap_widx_d;
  logic [N_CLNUM_BITS-1:0] heap_wclnum_q, heap_wclnum_d;
  logic [N_DATA_BITS-1:0]  heap_wdata_q, heap_wdata_d;
  logic                    err_q, err_d;

  logic          in_pkt, flit_acc, pop, push;
  logic [IW-1:0] pop_idx, push_idx;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    in_pkt     = (beats_rem_q != 2'd0);
    pop_idx    = fl_mem[rd_ptr_q];
    afu_wr_rdy = (state_q == ST_RUN) &&
                 (in_pkt || ((num_free_q != '0) && (!hdr_valid_q || hdr_rdy)));
    flit_acc   = afu_wr_valid && afu_wr_rdy;

    state_d       = state_q;
    beats_rem_d   = beats_rem_q;
    beat_cnt_d    = beat_cnt_q;
    pkt_idx_d     = pkt_idx_q;
    hdr_valid_d   = hdr_valid_q && !hdr_rdy;
    hdr_idx_d     = hdr_idx_q;
    heap_wen_d    = 1'b0;
    heap_widx_d   = heap_widx_q;
    heap_wclnum_d = heap_wclnum_q;
    heap_wdata_d  = heap_wdata_q;
    err_d         = err_q;
    pop           = 1'b0;
    push          = 1'b0;
    push_idx      = free_idx;

    unique case (state_q)
      ST_INIT: begin
        // Seed the free list with 0..N-1; wr_ptr doubles as the seed counter.
        push     = 1'b1;
        push_idx = wr_ptr_q;
        if (free_en) err_d = 1'b1;
        if (num_free_q == NUM_ENTRIES - (IW+1)'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flit_acc) begin
          if (afu_wr_sop) begin
            if (in_pkt || afu_wr_cl_len == 2'd2) begin
              err_d = 1'b1;
            end else begin
              pop           = 1'b1;
              hdr_valid_d   = 1'b1;
              hdr_idx_d     = pop_idx;
              pkt_idx_d     = pop_idx;
              beats_rem_d   = afu_wr_cl_len;
              beat_cnt_d    = '0;
              heap_wen_d    = 1'b1;
              heap_widx_d   = pop_idx;
              heap_wclnum_d = '0;
              heap_wdata_d  = afu_wr_data;
            end
          end else if (!in_pkt) begin
            err_d = 1'b1;
          end else begin
            beats_rem_d   = beats_rem_q - 2'd1;
            beat_cnt_d    = beat_cnt_q + N_CLNUM_BITS'(1);
            heap_wen_d    = 1'b1;
            heap_widx_d   = pkt_idx_q;
            heap_wclnum_d = beat_cnt_q + N_CLNUM_BITS'(1);
            heap_wdata_d  = afu_wr_data;
          end
        end
        if (free_en) begin
          if (num_free_q == NUM_ENTRIES) err_d = 1'b1;
          else                           push  = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    rd_ptr_d   = rd_ptr_q + IW'(pop);
    wr_ptr_d   = wr_ptr_q + IW'(push);
    num_free_d = num_free_q + (IW+1)'(push) - (IW+1)'(pop);
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      num_free_q    <= '0;
      beats_rem_q   <= '0;
      beat_cnt_q    <= '0;
      pkt_idx_q     <= '0;
      hdr_valid_q   <= 1'b0;
      hdr_idx_q     <= '0;
      heap_wen_q    <= 1'b0;
      heap_widx_q   <= '0;
      heap_wclnum_q <= '0;
      heap_wdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      num_free_q    <= num_free_d;
      beats_rem_q   <= beats_rem_d;
      beat_cnt_q    <= beat_cnt_d;
      pkt_idx_q     <= pkt_idx_d;
      hdr_valid_q   <= hdr_valid_d;
      hdr_idx_q     <= hdr_idx_d;
      heap_wen_q    <= heap_wen_d;
      heap_widx_q   <= heap_widx_d;
      heap_wclnum_q <= heap_wclnum_d;
      heap_wdata_q  <= heap_wdata_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the free-list storage is not reset; INIT rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (push) fl_mem[wr_ptr_q] <= push_idx;
  end

  assign hdr_valid   = hdr_valid_q;
  assign hdr_idx     = hdr_idx_q;
  assign heap_wen    = heap_wen_q;
  assign heap_widx   = heap_widx_q;
  assign heap_wclnum = heap_wclnum_q;
  assign heap_wdata  = heap_wdata_q;
  assign num_free    = num_free_q;
  assign err         = err_q;

endmodule
